adder_operand_loader: RTL

//  Sequencer upstream of the 5-bit ripple adder on the FPGA board. Captures two

---
 rtl/adder_operand_loader.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/adder_operand_loader.sv
// -----------------------------------------------------------------------------
// adder_operand_loader
//
// Sequencer that sits in front of an external WIDTH-bit ripple adder. Two
// operands are taken from the slide switches, one per debounced button press,
// and driven to the adder. The adder's {carry, sum} is registered one cycle
// later together with a valid flag for the display stage.
//
// Optional feature (macro ADDER_ACCUM_EN):
//   undefined : a press while showing a result returns to WAIT_A.
//   defined   : running accumulator. A press while showing a result feeds the
//               low WIDTH bits of the result back as operand A, takes operand
//               B from the switches, and re-sums.
//
// Parameters:
//   WIDTH            operand width, must match the adder
//   DEBOUNCE_CYCLES  cycles the synchronised button must hold a new level
//                    before it is accepted (>= 2)
//
// Ports:
//   clk           in   1        system clock, rising edge
//   rst_n         in   1        asynchronous active-low reset
//   sw            in   WIDTH    switch bank, operand source (static)
//   btn_load      in   1        raw, bouncing pushbutton
//   op_a          out  WIDTH    registered operand A to adder
//   op_b          out  WIDTH    registered operand B to adder
//   sum_in        in   WIDTH    adder sum
//   carry_in      in   1        adder carry-out
//   result        out  WIDTH+1  registered {carry_in, sum_in}
//   result_valid  out  1        high while result is current
//   state         out  2        FSM state for LEDs
// -----------------------------------------------------------------------------
module adder_operand_loader #(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_load,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             carry_in,
  output logic [WIDTH:0]   result,
  output logic             result_valid,
  output logic [1:0]       state
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_A = 2'b00,
    WAIT_B = 2'b01,
    SUM    = 2'b10,
    SHOW   = 2'b11
  } state_t;

  logic             btn_sync_p0;
  logic             btn_sync_p1;
  logic             btn_level;
  logic             press;
  logic [CNT_W-1:0] db_cnt;

  state_t           cur_state;
  state_t           nxt_state;
  logic [WIDTH-1:0] op_a_nxt;
  logic [WIDTH-1:0] op_b_nxt;
  logic [WIDTH:0]   result_nxt;
  logic             result_valid_nxt;

  // Stage p0/p1: two-flop synchroniser, then debounce counter.
  // The counter runs only while the synchronised button disagrees with the
  // accepted level; any return to agreement (a bounce) restarts it. press is
  // registered on the same edge the level rises, so it is high for exactly
  // one cycle and never on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync_p0 <= 1'b0;
      btn_sync_p1 <= 1'b0;
      btn_level   <= 1'b0;
      db_cnt      <= '0;
      press       <= 1'b0;
    end else begin
      btn_sync_p0 <= btn_load;
      btn_sync_p1 <= btn_sync_p0;
      press       <= 1'b0;
      if (btn_sync_p1 == btn_level) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_MAX) begin
        db_cnt    <= '0;
        btn_level <= btn_sync_p1;
        press     <= btn_sync_p1;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // FSM next-state and register updates. Operands and result hold unless
  // explicitly captured. SUM waits one cycle so the adder settles on the
  // registered operands before its output is sampled.
  always_comb begin
    nxt_state        = cur_state;
    op_a_nxt         = op_a;
    op_b_nxt         = op_b;
    result_nxt       = result;
    result_valid_nxt = result_valid;
    case (cur_state)
      WAIT_A: begin
        if (press) begin
          op_a_nxt  = sw;
          nxt_state = WAIT_B;
        end
      end
      WAIT_B: begin
        if (press) begin
          op_b_nxt  = sw;
          nxt_state = SUM;
        end
      end
      SUM: begin
        result_nxt       = {carry_in, sum_in};
        result_valid_nxt = 1'b1;
        nxt_state        = SHOW;
      end
      SHOW: begin
        if (press) begin
`ifdef ADDER_ACCUM_EN
          // Carry is dropped from the fed-back value: accumulation wraps
          // modulo 2^WIDTH.
          op_a_nxt         = result[WIDTH-1:0];
          op_b_nxt         = sw;
          result_valid_nxt = 1'b0;
          nxt_state        = SUM;
`else
          result_valid_nxt = 1'b0;
          nxt_state        = WAIT_A;
`endif
        end
      end
      default: nxt_state = WAIT_A;
    endcase
  end

  // Stage p2: FSM state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state    <= WAIT_A;
      op_a         <= '0;
      op_b         <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      cur_state    <= nxt_state;
      op_a         <= op_a_nxt;
      op_b         <= op_b_nxt;
      result       <= result_nxt;
      result_valid <= result_valid_nxt;
    end
  end

  assign state = cur_state;

endmodule
